odo_sbox_small_inv: RTL and testbench
=====================================

# odo_sbox_small_inv

Programmable inverse 6-bit S-box for the Odo small-S-box datapath. It accepts the 64-entry forward table through a write port and builds the inverse table with a 64-cycle scan, checking that the forward table is a bijection. It then serves registered inverse lookups with the same one-cycle latency as the forward small S-boxes. The block sits on the decrypt/verify side, opposite the forward `odo_sbox_small*` instances.

## Interface
- `W`, default 6: symbol width; the table holds 2^W entries. All values below are for W=6.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `load_valid`  in  1  write the forward-table entry on this edge
- `load_addr`  in  W  forward-table index
- `load_data`  in  W  forward-table value
- `build_start`  in  1  request an inverse-table build
- `busy`  out  1  build scan in progress
- `ready`  out  1  inverse table is valid and lookups are served
- `error`  out  1  last build found a non-bijective forward table
- `err_index`  out  W  forward index of the first duplicate found
- `in_valid`  in  1  lookup request
- `in`  in  W  lookup symbol
- `out_valid`  out  1  lookup result valid
- `out`  out  W  inverse value, `fwd^-1(in)`

## Operation
- Storage:
  - Forward table `fwd[64]` and inverse table `inv[64]` are not reset.
  - The `seen[64]` bitmap is cleared at every build start.
- FSM states are IDLE, SCAN, READY and ERR. Reset enters IDLE.
- Reset values: `busy`, `ready`, `error`, `err_index`, `out_valid` and `out` are all 0.
- Loads:
  - A load is accepted in IDLE, READY and ERR: `fwd[load_addr] <= load_data` on the edge.
  - A load in READY moves the FSM to IDLE, so the table is treated as stale and `ready` drops.
  - A load in ERR keeps the FSM in ERR.
  - A load during SCAN is ignored, with no write.
- Starting a build:
  - `build_start` is accepted in IDLE, READY and ERR. It clears `seen`, `error` and `err_index`, sets the index `i=0` and enters SCAN.
  - `build_start` during SCAN is ignored.
  - If `load_valid` and `build_start` arrive together, the write is applied on the same edge and the scan sees the new value.
- SCAN runs one index per cycle:
  - `v = fwd[i]`, then `inv[v] <= i` and `seen[v] <= 1`.
  - If `seen[v]` was already set and `error` is still 0: `error <= 1` and `err_index <= i`. Later duplicates do not change `err_index`.
  - After `i=63`, go to READY if no duplicate was found, otherwise to ERR.
- Lookups:
  - Served only in READY. When `in_valid` is high, `out <= inv[in]` and `out_valid <= 1` on the next edge.
  - In any other state, and whenever `in_valid` is 0, `out_valid <= 0` and `out` holds its last value.
  - Lookups are fully pipelined, one per cycle, with no backpressure.
- ERR: `ready=0`. The contents of `inv` are undefined and are never exposed.
- All index arithmetic is unsigned W-bit; `i` wraps only at the terminal compare, never to 0 in SCAN.

## Timing
- `build_start` sampled at edge T:
  - `busy=1` for cycles T+1..T+64, one scan index per cycle.
  - `busy=0` from T+65, together with `ready=1` or `error=1`.
- `error` can rise during the scan, on the cycle after the duplicate index is scanned.
- A load accepted in READY at edge T gives `ready=0` from T+1. A lookup sampled at edge T is still served.
- Lookup latency: `in_valid` at edge T gives `out_valid`/`out` at T+1.
- `rst` asserted at any time, including mid-scan, immediately forces IDLE and the output reset values. The build is not resumed; a new `build_start` is required.

## Test plan
- Reset check: assert `rst`, then release it with no other stimulus → all outputs 0. A lookup with `in_valid=1` then gives `out_valid=0`.
- Basic build and lookup:
  - Load `fwd[x]=(x+5) mod 64` for all x, then pulse `build_start` at T → `busy` high exactly for T+1..T+64, `ready=1` at T+65, `error=0`.
  - Lookup `in=6'h02` → `out=6'h3D` one cycle later.
  - Lookup `in=6'h05` → `out=6'h00`.
- Duplicate detection:
  - Load identity except `fwd[7]=6'h03` and `fwd[40]=6'h03` → `error=1` from T+9, `err_index=7`.
  - At T+65: `ready=0`, and lookups give `out_valid=0`.
- Stale table: after a good build, load `fwd[0]=6'h3F` → `ready=0` on the next cycle and lookups are ignored. A rebuild with a bijective table restores `ready=1` at T+65.
- Reset mid-scan: assert `rst` while the scan is at index 30 → `busy`, `ready` and `error` go to 0 immediately. After release, a new build completes normally.
- Streaming: with `ready=1` on the `(x+5)` table, drive `in=0..63` on consecutive cycles with `in_valid=1` → `out` sequence is `(in-5) mod 64`, in order, one cycle behind, with `out_valid` continuously high.

Source files
------------

// File: rtl/odo_sbox_small_inv.sv
// Programmable inverse W-bit S-box for the Odo small-S-box datapath.
//
// The forward table is written through the load port. A build request then
// scans the forward table one index per cycle. The scan fills the inverse
// table and checks that the forward table is a bijection. Once a build
// succeeds, registered inverse lookups are served with one-cycle latency.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   load_valid   write fwd[load_addr] = load_data (ignored while scanning)
//   load_addr    forward-table index
//   load_data    forward-table value
//   build_start  request an inverse-table build (ignored while scanning)
//   busy         build scan in progress
//   ready        inverse table valid, lookups served
//   error        last build found a non-bijective forward table
//   err_index    forward index of the first duplicate found
//   in_valid     lookup request
//   in           lookup symbol
//   out_valid    lookup result valid
//   out          inverse value fwd^-1(in)
module odo_sbox_small_inv #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  input  logic [W-1:0] load_addr,
  input  logic [W-1:0] load_data,
  input  logic         build_start,
  output logic         busy,
  output logic         ready,
  output logic         error,
  output logic [W-1:0] err_index,
  input  logic         in_valid,
  input  logic [W-1:0] in,
  output logic         out_valid,
  output logic [W-1:0] out
);

  localparam int unsigned Depth = 2 ** W;

  typedef enum logic [1:0] {StIdle, StScan, StReady, StErr} state_e;

  state_e           state_q;
  logic [W-1:0]     idx_q;
  logic [Depth-1:0] seen_q;
  logic             error_q;
  logic [W-1:0]     err_index_q;
  logic             out_valid_q;
  logic [W-1:0]     out_q;

  // Table storage is deliberately left unreset.
  logic [W-1:0] fwd_mem [Depth];
  logic [W-1:0] inv_mem [Depth];

  logic         load_ok;
  logic         start_ok;
  logic [W-1:0] scan_val;
  logic         scan_dup;
  logic         scan_last;

  always_comb begin
    load_ok   = load_valid && (state_q != StScan);
    start_ok  = build_start && (state_q != StScan);
    scan_val  = fwd_mem[idx_q];
    scan_dup  = seen_q[scan_val];
    scan_last = (idx_q == W'(Depth - 1));
  end

  // Table writes. A load on the same edge as build_start lands before the
  // first scan read, so the scan sees the new value.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      fwd_mem[load_addr] <= load_data;
    end
    if (state_q == StScan) begin
      inv_mem[scan_val] <= idx_q;
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      seen_q      <= '0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      unique case (state_q)
        StScan: begin
          seen_q[scan_val] <= 1'b1;
          // Only the first duplicate is recorded.
          if (scan_dup && !error_q) begin
            error_q     <= 1'b1;
            err_index_q <= idx_q;
          end
          if (scan_last) begin
            state_q <= (error_q || scan_dup) ? StErr : StReady;
          end else begin
            idx_q <= idx_q + W'(1);
          end
        end
        StIdle, StReady, StErr: begin
          if (start_ok) begin
            state_q     <= StScan;
            idx_q       <= '0;
            seen_q      <= '0;
            error_q     <= 1'b0;
            err_index_q <= '0;
          end else if (load_valid && (state_q == StReady)) begin
            // Any table write invalidates the inverse table.
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Lookup pipeline: decided on the pre-edge state, so a lookup that
      // coincides with a stale-making load is still served.
      if ((state_q == StReady) && in_valid) begin
        out_valid_q <= 1'b1;
        out_q       <= inv_mem[in];
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    busy      = (state_q == StScan);
    ready     = (state_q == StReady);
    error     = error_q;
    err_index = err_index_q;
    out_valid = out_valid_q;
    out       = out_q;
  end

endmodule

// File: tb/tb_odo_sbox_small_inv.sv
module tb_odo_sbox_small_inv;

  localparam int W = 6;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_addr = '0;
  logic [W-1:0] load_data = '0;
  logic         build_start = 1'b0;
  logic         busy;
  logic         ready;
  logic         error;
  logic [W-1:0] err_index;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_sym = '0;
  logic         out_valid;
  logic [W-1:0] out_sym;

  int checks = 0;
  int errors = 0;
  int fwd_m [N];

  odo_sbox_small_inv #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .build_start(build_start),
    .busy       (busy),
    .ready      (ready),
    .error      (error),
    .err_index  (err_index),
    .in_valid   (in_valid),
    .in         (in_sym),
    .out_valid  (out_valid),
    .out        (out_sym)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: first forward index whose value already appeared.
  function automatic int first_dup();
    bit seen [N];
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (seen[fwd_m[i]]) return i;
      seen[fwd_m[i]] = 1'b1;
    end
    return -1;
  endfunction

  function automatic int inv_of(input int y);
    for (int x = 0; x < N; x++) if (fwd_m[x] == y) return x;
    return -1;
  endfunction

  task automatic set_shift(input int k);
    for (int x = 0; x < N; x++) fwd_m[x] = (x + k) % N;
  endtask

  task automatic set_random_perm();
    int j, t;
    for (int x = 0; x < N; x++) fwd_m[x] = x;
    for (int x = N - 1; x > 0; x--) begin
      j = $urandom_range(x, 0);
      t = fwd_m[x]; fwd_m[x] = fwd_m[j]; fwd_m[j] = t;
    end
  endtask

  task automatic load_all();
    for (int x = 0; x < N; x++) begin
      load_valid = 1'b1;
      load_addr  = W'(x);
      load_data  = W'(fwd_m[x]);
      step();
    end
    load_valid = 1'b0;
  endtask

  // Pulse build_start and follow the scan, checking timing and result.
  task automatic do_build(input string tag);
    int dup, n, err_at, exp_at;
    dup = first_dup();
    exp_at = (dup < 0) ? -1 : dup + 1;
    build_start = 1'b1;
    step();
    build_start = 1'b0;
    n = 0;
    err_at = -1;
    while (busy === 1'b1 && n < 100) begin
      if (error === 1'b1 && err_at < 0) err_at = n;
      n++;
      step();
    end
    if (error === 1'b1 && err_at < 0) err_at = n;
    chk({tag, "_busy_cycles"}, n, 64);
    chk({tag, "_ready"}, ready, (dup < 0) ? 1 : 0);
    chk({tag, "_error"}, error, (dup < 0) ? 0 : 1);
    chk({tag, "_err_index"}, err_index, (dup < 0) ? 0 : dup);
    chk({tag, "_err_rise"}, err_at, exp_at);
  endtask

  task automatic lookup(input string tag, input int sym, input int exp_valid, input int exp_out);
    in_valid = 1'b1;
    in_sym   = W'(sym);
    step();
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, out_valid, exp_valid);
    if (exp_valid != 0) chk({tag, "_out"}, out_sym, exp_out);
  endtask

  initial begin
    int a, b, s;
    logic [W-1:0] last_out;

    // Reset
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_error", error, 0);
    chk("rst_err_index", err_index, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out_sym, 0);
    lookup("rst_lookup", $urandom_range(N - 1, 0), 0, 0);

    // Basic build on (x+5) table
    set_shift(5);
    load_all();
    do_build("basic");
    lookup("basic_lk02", 6'h02, 1, 6'h3D);
    lookup("basic_lk05", 6'h05, 1, 6'h00);

    // Streaming 0..63 back to back
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_sym   = W'(k);
      step();
      chk($sformatf("stream_valid_%0d", k), out_valid, 1);
      chk($sformatf("stream_out_%0d", k), out_sym, (k - 5 + N) % N);
    end
    in_valid = 1'b0;
    last_out = out_sym;
    step();
    chk("stream_idle_valid", out_valid, 0);
    chk("stream_idle_hold", out_sym, last_out);

    // Duplicate detection
    for (int x = 0; x < N; x++) fwd_m[x] = x;
    fwd_m[7]  = 6'h03;
    fwd_m[40] = 6'h03;
    load_all();
    do_build("dup");
    lookup("dup_lookup", 6'h03, 0, 0);
    chk("dup_ready_hold", ready, 0);
    load_valid = 1'b1; load_addr = 6'd7; load_data = 6'd7; fwd_m[7] = 7;
    step();
    load_valid = 1'b0;
    chk("dup_load_in_err_error", error, 1);
    chk("dup_load_in_err_ready", ready, 0);

    // Stale table after good build
    set_shift(5);
    load_all();
    do_build("stale_pre");
    load_valid = 1'b1; load_addr = 6'h00; load_data = 6'h3F;
    in_valid = 1'b1; in_sym = 6'h02;
    step();
    load_valid = 1'b0; in_valid = 1'b0;
    fwd_m[0] = 6'h3F;
    chk("stale_ready", ready, 0);
    chk("stale_same_edge_valid", out_valid, 1);
    chk("stale_same_edge_out", out_sym, 6'h3D);
    lookup("stale_lookup", 6'h02, 0, 0);
    load_valid = 1'b1; load_addr = 6'h00; load_data = 6'h05;
    step();
    load_valid = 1'b0;
    fwd_m[0] = 5;
    do_build("stale_rebuild");
    lookup("stale_rebuild_lk", 6'h3D, 1, 6'h38);

    // Randomized bijections with random lookups
    for (int r = 0; r < 3; r++) begin
      set_random_perm();
      load_all();
      do_build($sformatf("rand%0d", r));
      for (int k = 0; k < 16; k++) begin
        s = $urandom_range(N - 1, 0);
        lookup($sformatf("rand%0d_lk%0d", r, k), s, 1, inv_of(s));
      end
    end

    // Randomized single duplicate
    set_random_perm();
    a = $urandom_range(N - 2, 0);
    b = $urandom_range(N - 1, a + 1);
    fwd_m[b] = fwd_m[a];
    load_all();
    do_build("rand_dup");

    // Reset mid-scan (duplicate at 10 so error is already high)
    for (int x = 0; x < N; x++) fwd_m[x] = x;
    fwd_m[10] = 3;
    load_all();
    build_start = 1'b1;
    step();
    build_start = 1'b0;
    repeat (30) step();
    chk("midrst_pre_busy", busy, 1);
    chk("midrst_pre_error", error, (first_dup() >= 0 && first_dup() < 30) ? 1 : 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_error", error, 0);
    chk("midrst_err_index", err_index, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("midrst_idle_busy", busy, 0);
    set_shift(5);
    load_all();
    do_build("midrst_rebuild");
    lookup("midrst_lk", 6'h00, 1, 6'h3B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
